// File: rtl/meas_sequencer.sv
// meas_sequencer
//   Measurement sequencer for the pulse-counting datapath. Selects the count
//   source (ADC or AVK), aligns to the 5 ms window tick, accumulates
//   per-window deltas of the free-running count_p/count_m over n_win windows
//   and publishes the latched result through a valid/ack handshake.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start; results and source select hold
//   S_ALIGN  | waiting for the first window tick to take the count base
//   S_SETTLE | discarding SETTLE_WIN windows after a channel switch
//   S_ACCUM  | accumulating window deltas, publishing every n_win windows
//
// Ports
//   clk, async_reset       12 MHz clock, async active-high reset
//   win_tick_i             one-clk pulse per window boundary
//   count_p_i, count_m_i   free-running counts (CNT_W)
//   start_i, abort_i       one-clk sequence control pulses (abort wins)
//   mode_i                 00 ADC, 01 AVK, 10 alternate, 11 as 00
//   n_win_i                windows per result, 0 treated as 1
//   cnt_choise_o           source select: 0 ADC, 1 AVK
//   busy_o                 high while not idle
//   res_valid_o, res_ack_i result handshake
//   res_chan_o, res_p_o, res_m_o  latched result
//   overrun_o              sticky: result overwritten before ack
module meas_sequencer #(
  parameter int CNT_W      = 24,
  parameter int ACC_W      = 32,
  parameter int SETTLE_WIN = 1
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             win_tick_i,
  input  logic [CNT_W-1:0] count_p_i,
  input  logic [CNT_W-1:0] count_m_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       n_win_i,
  output logic             cnt_choise_o,
  output logic             busy_o,
  output logic             res_valid_o,
  output logic             res_chan_o,
  output logic [ACC_W-1:0] res_p_o,
  output logic [ACC_W-1:0] res_m_o,
  input  logic             res_ack_i,
  output logic             overrun_o
);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_SETTLE, S_ACCUM} state_t;

  localparam logic [3:0] SETTLE_N   = 4'(SETTLE_WIN);
  localparam bit         HAS_SETTLE = (SETTLE_WIN != 0);

  state_t state_q, state_d;

  logic             alt_q, alt_d;
  logic [7:0]       n_win_q, n_win_d;
  logic             cnt_choise_q, cnt_choise_d;
  logic [CNT_W-1:0] base_p_q, base_p_d, base_m_q, base_m_d;
  logic [ACC_W-1:0] acc_p_q, acc_p_d, acc_m_q, acc_m_d;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic             res_valid_q, res_valid_d;
  logic             res_chan_q, res_chan_d;
  logic [ACC_W-1:0] res_p_q, res_p_d, res_m_q, res_m_d;
  logic             overrun_q, overrun_d;

  logic go, tick_live, settle_tick, accum_tick, publish;
  logic win_last, settle_last;

  logic [CNT_W-1:0] delta_p, delta_m;
  logic [ACC_W:0]   sum_p, sum_m;
  logic [ACC_W-1:0] acc_p_next, acc_m_next;

  assign win_last    = (win_cnt_q + 8'd1) == n_win_q;
  assign settle_last = (settle_cnt_q + 4'd1) == SETTLE_N;

  // Modular difference handles counter wrap; the wider sum exposes the
  // carry used for saturation.
  assign delta_p    = count_p_i - base_p_q;
  assign delta_m    = count_m_i - base_m_q;
  assign sum_p      = {1'b0, acc_p_q} + {{(ACC_W + 1 - CNT_W){1'b0}}, delta_p};
  assign sum_m      = {1'b0, acc_m_q} + {{(ACC_W + 1 - CNT_W){1'b0}}, delta_m};
  assign acc_p_next = sum_p[ACC_W] ? '1 : sum_p[ACC_W-1:0];
  assign acc_m_next = sum_m[ACC_W] ? '1 : sum_m[ACC_W-1:0];

  // State register
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_i) state_d = S_ALIGN;
        S_ALIGN:  if (win_tick_i) state_d = HAS_SETTLE ? S_SETTLE : S_ACCUM;
        S_SETTLE: if (win_tick_i && settle_last) state_d = S_ACCUM;
        S_ACCUM:  if (win_tick_i && win_last && alt_q && HAS_SETTLE) state_d = S_SETTLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output / strobe logic
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    go          = (state_q == S_IDLE) && start_i && !abort_i;
    tick_live   = busy_o && win_tick_i && !abort_i;
    settle_tick = tick_live && (state_q == S_SETTLE);
    accum_tick  = tick_live && (state_q == S_ACCUM);
    publish     = accum_tick && win_last;
  end

  // Datapath next-state
  always_comb begin
    alt_d        = alt_q;
    n_win_d      = n_win_q;
    cnt_choise_d = cnt_choise_q;
    base_p_d     = base_p_q;
    base_m_d     = base_m_q;
    acc_p_d      = acc_p_q;
    acc_m_d      = acc_m_q;
    win_cnt_d    = win_cnt_q;
    settle_cnt_d = settle_cnt_q;
    res_valid_d  = res_valid_q;
    res_chan_d   = res_chan_q;
    res_p_d      = res_p_q;
    res_m_d      = res_m_q;
    overrun_d    = overrun_q;

    if (go) begin
      alt_d        = (mode_i == 2'b10);
      n_win_d      = (n_win_i == 8'd0) ? 8'd1 : n_win_i;
      cnt_choise_d = (mode_i == 2'b01);
      overrun_d    = 1'b0;
      acc_p_d      = '0;
      acc_m_d      = '0;
      win_cnt_d    = '0;
      settle_cnt_d = '0;
    end

    // Every live tick rebases, so each window contributes only its own delta.
    if (tick_live) begin
      base_p_d = count_p_i;
      base_m_d = count_m_i;
    end

    if (settle_tick) begin
      settle_cnt_d = settle_last ? 4'd0 : settle_cnt_q + 4'd1;
    end

    if (accum_tick) begin
      if (win_last) begin
        acc_p_d   = '0;
        acc_m_d   = '0;
        win_cnt_d = '0;
      end else begin
        acc_p_d   = acc_p_next;
        acc_m_d   = acc_m_next;
        win_cnt_d = win_cnt_q + 8'd1;
      end
    end

    // A publish coinciding with an ack keeps the new result valid.
    if (publish) begin
      res_p_d     = acc_p_next;
      res_m_d     = acc_m_next;
      res_chan_d  = cnt_choise_q;
      res_valid_d = 1'b1;
      if (res_valid_q && !res_ack_i) overrun_d = 1'b1;
      if (alt_q) cnt_choise_d = ~cnt_choise_q;
    end else if (res_ack_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      alt_q        <= 1'b0;
      n_win_q      <= 8'd0;
      cnt_choise_q <= 1'b0;
      base_p_q     <= '0;
      base_m_q     <= '0;
      acc_p_q      <= '0;
      acc_m_q      <= '0;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
      res_valid_q  <= 1'b0;
      res_chan_q   <= 1'b0;
      res_p_q      <= '0;
      res_m_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      alt_q        <= alt_d;
      n_win_q      <= n_win_d;
      cnt_choise_q <= cnt_choise_d;
      base_p_q     <= base_p_d;
      base_m_q     <= base_m_d;
      acc_p_q      <= acc_p_d;
      acc_m_q      <= acc_m_d;
      win_cnt_q    <= win_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      res_valid_q  <= res_valid_d;
      res_chan_q   <= res_chan_d;
      res_p_q      <= res_p_d;
      res_m_q      <= res_m_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cnt_choise_o = cnt_choise_q;
  assign res_valid_o  = res_valid_q;
  assign res_chan_o   = res_chan_q;
  assign res_p_o      = res_p_q;
  assign res_m_o      = res_m_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// tb_meas_sequencer
//   Bench for meas_sequencer: a short vector table, a few hand-built corner
//   sequences and a randomized run, all compared against a window-level
//   reference model (tick index arithmetic over recorded count samples).
module tb_meas_sequencer;
  localparam int S = 1;

  logic        clk = 1'b0;
  logic        async_reset;
  logic        win_tick, start, abort, res_ack;
  logic [23:0] count_p, count_m;
  logic [1:0]  mode;
  logic [7:0]  n_win;
  logic        cnt_choise, busy, res_valid, res_chan, overrun;
  logic [31:0] res_p, res_m;

  always #5 clk = ~clk;

  meas_sequencer #(.CNT_W(24), .ACC_W(32), .SETTLE_WIN(S)) dut (
    .clk(clk), .async_reset(async_reset), .win_tick_i(win_tick),
    .count_p_i(count_p), .count_m_i(count_m), .start_i(start), .abort_i(abort),
    .mode_i(mode), .n_win_i(n_win), .cnt_choise_o(cnt_choise), .busy_o(busy),
    .res_valid_o(res_valid), .res_chan_o(res_chan), .res_p_o(res_p),
    .res_m_o(res_m), .res_ack_i(res_ack), .overrun_o(overrun)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: sequence activity, tick index since start, and the
  // count samples taken at each tick.
  bit          m_active, m_alt, m_chan, m_valid, m_over, m_rchan;
  int          m_n, m_k;
  logic [31:0] m_p, m_m;
  logic [23:0] qp[$], qm[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_alt = 0; m_chan = 0; m_valid = 0; m_over = 0; m_rchan = 0;
    m_n = 1; m_k = 0; m_p = 0; m_m = 0;
    qp.delete(); qm.delete();
  endtask

  // Tick 1 aligns; in continuous modes S ticks settle once and then every
  // n-th tick publishes; in alternate mode each result is S+n ticks apart.
  function automatic bit is_result(input int k);
    if (m_alt) return (k > 1) && ((k - 1) % (S + m_n) == 0);
    return (k > 1 + S) && ((k - 1 - S) % m_n == 0);
  endfunction

  function automatic logic [31:0] seg_sum(input bit neg);
    longint      s;
    logic [23:0] d;
    s = 0;
    for (int i = qp.size() - m_n; i < qp.size(); i++) begin
      d = neg ? (qm[i] - qm[i-1]) : (qp[i] - qp[i-1]);
      s += longint'(d);
    end
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    return s[31:0];
  endfunction

  task automatic model_edge();
    bit pub;
    pub = 0;
    if (abort) begin
      m_active = 0;
    end else if (start && !m_active) begin
      m_active = 1;
      m_alt    = (mode == 2'b10);
      m_n      = (n_win == 0) ? 1 : int'(n_win);
      m_chan   = (mode == 2'b01);
      m_over   = 0;
      m_k      = 0;
      qp.delete(); qm.delete();
    end else if (m_active && win_tick) begin
      m_k++;
      qp.push_back(count_p);
      qm.push_back(count_m);
      if (is_result(m_k)) begin
        pub = 1;
        m_p = seg_sum(0);
        m_m = seg_sum(1);
        if (m_valid && !res_ack) m_over = 1;
        m_valid = 1;
        m_rchan = m_chan;
        if (m_alt) m_chan = !m_chan;
      end
    end
    if (res_ack && !pub) m_valid = 0;
  endtask

  task automatic model_check();
    chk("busy", busy, m_active);
    chk("res_valid", res_valid, m_valid);
    chk("res_chan", res_chan, m_rchan);
    chk("res_p", res_p, m_p);
    chk("res_m", res_m, m_m);
    chk("cnt_choise", cnt_choise, m_chan);
    chk("overrun", overrun, m_over);
  endtask

  // Called at a falling edge: drive, clock, update model, check.
  task automatic step(input bit t, input bit a, input bit s, input bit ab);
    win_tick = t; res_ack = a; start = s; abort = ab;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    win_tick = 0; res_ack = 0; start = 0; abort = 0;
    model_check();
  endtask

  task automatic tick(input int dp, input int dm);
    count_p = count_p + 24'(dp);
    count_m = count_m + 24'(dm);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic restart(input logic [1:0] md, input logic [7:0] nw);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    mode = md; n_win = nw;
    step(0, 0, 1, 0);
    mode = ~md; n_win = nw + 8'd3;
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [7:0]  nw;
    int          dp, dm;
    logic [31:0] ep, em;
    logic        ec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b00, 8'd2, 100, 40, 32'd200, 32'd80, 1'b0};
    vecs[1] = '{2'b01, 8'd3, 7, 5, 32'd21, 32'd15, 1'b1};
    vecs[2] = '{2'b00, 8'd0, 9, 3, 32'd9, 32'd3, 1'b0};
    vecs[3] = '{2'b11, 8'd2, 50, 60, 32'd100, 32'd120, 1'b0};
    vecs[4] = '{2'b10, 8'd1, 30, 20, 32'd30, 32'd20, 1'b0};
    vecs[5] = '{2'b00, 8'd4, 32'h40_0000, 1, 32'h100_0000, 32'd4, 1'b0};

    async_reset = 1; win_tick = 0; start = 0; abort = 0; res_ack = 0;
    count_p = 0; count_m = 0; mode = 0; n_win = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset res_p", res_p, 0);
    chk("reset cnt_choise", cnt_choise, 0);
    chk("reset overrun", overrun, 0);
    async_reset = 0;
    step(0, 0, 0, 0);

    // Table vectors: one full result per vector.
    foreach (vecs[v]) begin
      int nt;
      restart(vecs[v].md, vecs[v].nw);
      nt = 1 + S + ((vecs[v].nw == 0) ? 1 : int'(vecs[v].nw));
      for (int i = 0; i < nt - 1; i++) tick(vecs[v].dp, vecs[v].dm);
      chk("vec early valid", res_valid, 0);
      tick(vecs[v].dp, vecs[v].dm);
      chk("vec res_valid", res_valid, 1);
      chk("vec res_p", res_p, vecs[v].ep);
      chk("vec res_m", res_m, vecs[v].em);
      chk("vec res_chan", res_chan, vecs[v].ec);
      chk("vec busy", busy, 1);
    end

    // Count wrap across the accumulated window.
    restart(2'b00, 8'd1);
    count_p = 24'hFFFFE0;
    tick(0, 1);
    tick(16, 1);
    tick(32, 1);
    chk("wrap res_p", res_p, 32'h20);
    chk("wrap res_m", res_m, 32'd1);

    // Alternate mode, no ack between the two publishes.
    restart(2'b10, 8'd1);
    tick(5, 1); tick(5, 1); tick(5, 1);
    chk("alt1 res_chan", res_chan, 0);
    chk("alt1 cnt_choise", cnt_choise, 1);
    chk("alt1 res_p", res_p, 32'd5);
    tick(7, 2); tick(7, 2);
    chk("alt2 res_chan", res_chan, 1);
    chk("alt2 cnt_choise", cnt_choise, 0);
    chk("alt2 overrun", overrun, 1);
    chk("alt2 res_p", res_p, 32'd7);

    // New start clears overrun; ack coincident with publish.
    step(0, 0, 0, 1);
    mode = 2'b00; n_win = 8'd1;
    step(0, 0, 1, 0);
    chk("restart overrun", overrun, 0);
    step(0, 1, 0, 0);
    tick(1, 1); tick(1, 1); tick(1, 1);
    chk("pre-ack res_valid", res_valid, 1);
    count_p = count_p + 24'd3;
    step(1, 1, 0, 0);
    chk("ack+pub res_valid", res_valid, 1);
    chk("ack+pub overrun", overrun, 0);
    chk("ack+pub res_p", res_p, 32'd3);

    // Abort holds results; later ticks are ignored.
    step(0, 0, 0, 1);
    chk("abort busy", busy, 0);
    chk("abort res_valid", res_valid, 1);
    tick(50, 50);
    chk("abort tick res_p", res_p, 32'd3);

    // Start while busy is ignored.
    restart(2'b00, 8'd2);
    tick(4, 4); tick(4, 4); tick(4, 4);
    mode = 2'b01; n_win = 8'd1;
    step(0, 0, 1, 0);
    tick(4, 4);
    chk("busy start res_p", res_p, 32'd8);
    chk("busy start cnt_choise", cnt_choise, 0);

    // Asynchronous reset mid-accumulation.
    restart(2'b01, 8'd4);
    tick(9, 9); tick(9, 9); tick(9, 9);
    #2 async_reset = 1;
    #1;
    chk("areset busy", busy, 0);
    chk("areset res_valid", res_valid, 0);
    chk("areset res_p", res_p, 0);
    chk("areset cnt_choise", cnt_choise, 0);
    model_reset();
    @(negedge clk);
    async_reset = 0;
    step(0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        count_p = 24'($urandom);
        count_m = 24'($urandom);
      end else begin
        count_p = count_p + 24'($urandom_range(0, 300));
        count_m = count_m + 24'($urandom_range(0, 300));
      end
      mode  = 2'($urandom_range(0, 3));
      n_win = 8'($urandom_range(0, 4));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
